// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//   Flow-controlled pipeline stage register used between pipeline stages.
//   Two-entry skid storage (main = head, skid = second beat) gives full
//   throughput under back-pressure, while in_ready_o stays a pure decode
//   of registered state. Synchronous flush empties the stage. A saturating
//   counter records how many cycles the head beat was stalled.
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous reset, active low
//   flush_i         synchronous flush, discards held and incoming beats
//   in_valid_i      upstream beat present
//   in_ready_o      stage can accept a beat this cycle
//   in_data_i       upstream payload
//   out_valid_o     head beat present
//   out_ready_i     downstream accepts the head beat this cycle
//   out_data_o      head payload, BUBBLE_VALUE when out_valid_o=0
//   stall_cycles_o  cycles with out_valid_o=1 and out_ready_i=0 (saturating)
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int unsigned             WIDTH        = 64,
   parameter logic [WIDTH-1:0]        BUBBLE_VALUE = {WIDTH{1'b0}},
   parameter int unsigned             CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [CNT_W-1:0] stall_cycles_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   occ_e             state_q, state_d;
   logic [WIDTH-1:0] main_q,  main_d;
   logic [WIDTH-1:0] skid_q,  skid_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic in_fire;
   logic out_fire;

   // Handshake outputs decode registered state only, so in_ready_o has no
   // combinational path from out_ready_i.
   assign in_ready_o     = (state_q != FULL);
   assign out_valid_o    = (state_q != EMPTY);
   assign out_data_o     = out_valid_o ? main_q : BUBBLE_VALUE;
   assign stall_cycles_o = stall_q;

   assign in_fire  = in_valid_i  & in_ready_o;
   assign out_fire = out_valid_o & out_ready_i;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         // Payload registers keep stale data; outputs are masked by EMPTY.
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data_i;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_fire && !out_fire) begin
                  skid_d  = in_data_i;
                  state_d = FULL;
               end else if (!in_fire && out_fire) begin
                  state_d = EMPTY;
               end else if (in_fire && out_fire) begin
                  // Head leaves and new beat replaces it: no bubble.
                  main_d  = in_data_i;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Counter is independent of flush; saturates at all-ones.
   always_comb begin
      stall_d = stall_q;
      if (out_valid_o && !out_ready_i && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE_VALUE;
         skid_q  <= BUBBLE_VALUE;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         stall_q <= stall_d;
      end
   end

endmodule
